// File: rtl/csa_serial_adder_seq_pkg.sv
// Shared constants for the slice-serial adder: FSM encoding, slice width
// and the slice-counter width helper.
package csa_serial_adder_seq_pkg;

    localparam int SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter width for NSLICE slices; never narrower than one bit
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/carry_select_adder_4bit.sv
// 4-bit carry-select adder: both carry-in hypotheses are computed in
// parallel and the real carry-in picks one. Purely combinational.
module carry_select_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] sum0, sum1;
    logic       cout0, cout1;

    ripple_carry_4_bit u_rca0 (.a(a), .b(b), .cin(1'b0), .sum(sum0), .cout(cout0));
    ripple_carry_4_bit u_rca1 (.a(a), .b(b), .cin(1'b1), .sum(sum1), .cout(cout1));

    mux2X1_parameter #(.WIDTH(5)) u_sel (
        .in0 ({cout0, sum0}),
        .in1 ({cout1, sum1}),
        .sel (cin),
        .out ({cout, sum})
    );

endmodule

// File: rtl/mux2X1_parameter.sv
// Parameterised 2:1 multiplexer used by the carry-select stage.
module mux2X1_parameter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/ripple_carry_4_bit.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry bit by bit through four full adders
    always_comb begin
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/csa_serial_adder_seq.sv
// Slice-serial WIDTH-bit adder: operands are accepted over a valid/ready
// handshake, fed 4 bits per cycle through one carry-select adder with the
// slice carry registered in between, and the result is offered over a
// second valid/ready handshake.
module csa_serial_adder_seq
    import csa_serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("csa_serial_adder_seq: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    carry_select_adder_4bit u_csa (
        .a    (a_sh_q[SLICE_W-1:0]),
        .b    (b_sh_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state logic: load on accept, shift one slice per RUN cycle,
    // capture the result on the last slice, release on consumer accept
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                sum_sh_d = {slice_sum, sum_sh_q[WIDTH-1:SLICE_W]};
                carry_d  = slice_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // The final slice lands in sum_sh_d this same cycle
                    sum_d   = sum_sh_d;
                    cout_d  = slice_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_csa_serial_adder_seq.sv
// Testbench for csa_serial_adder_seq: a 32-bit and an 8-bit instance,
// each with a result scoreboard checked on the output handshake.
module tb_csa_serial_adder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;

    // 32-bit instance signals
    logic        in_valid, in_ready, out_valid, out_ready, busy, cin, cout;
    logic [31:0] a, b, sum;
    // 8-bit instance signals
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, cin8, cout8;
    logic [7:0]  a8, b8, sum8;

    logic [32:0] sb_q[$];
    logic [8:0]  sb8_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    csa_serial_adder_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    csa_serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: compare on the cycle the result handshake completes
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk_eq("sb32_unexpected", 64'(out_valid), 64'd0);
            else chk_eq("sb32_result", 64'({cout, sum}), 64'(sb_q.pop_front()));
        end
        if (rst_n && out_valid8 && out_ready8) begin
            if (sb8_q.size() == 0) chk_eq("sb8_unexpected", 64'(out_valid8), 64'd0);
            else chk_eq("sb8_result", 64'({cout8, sum8}), 64'(sb8_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready();
        int k = 0;
        while (!in_ready && k < 100) begin step(); k++; end
        chk_eq("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    // Present one operand set, push its expected result, return after accept
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        wait_in_ready();
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        sb_q.push_back({1'b0, va} + {1'b0, vb} + 33'(vc));
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen
    task automatic wait_out_valid(output int k);
        k = 0;
        while (!out_valid && k < 100) begin step(); k++; end
    endtask

    initial begin
        int lat, t0, t1;
        logic [31:0] hold_sum;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; cin8 = 0;
        #1;
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_sum_cout", 64'({cout, sum}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Wrap-around carry and 8-cycle latency
        send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        wait_out_valid(lat);
        chk_eq("latency32", 64'(lat), 64'd8);

        // Mixed operands with carry-in; busy/in_ready during RUN and DONE
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        chk_eq("run_busy", 64'(busy), 64'd1);
        chk_eq("run_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b0;
        wait_out_valid(lat);
        chk_eq("done_busy", 64'(busy), 64'd1);
        chk_eq("done_in_ready", 64'(in_ready), 64'd0);
        chk_eq("done_sum", 64'(sum), 64'h0000_0000_ACF1_3569);
        out_ready = 1'b1;
        step();

        // Backpressure: result held and new requests ignored
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_out_valid(lat);
        hold_sum = sum;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; a = $urandom; b = $urandom;
            step();
            chk_eq("bp_hold", 64'({out_valid, cout, sum}), {31'd0, 1'b1, 1'b1, hold_sum});
        end
        chk_eq("bp_value", 64'({cout, sum}), 64'h1_FFFF_FFFF);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk_eq("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk_eq("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset during slice 3 discards the operation
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        chk_eq("arst_sum_cout", 64'({cout, sum}), 64'd0);
        sb_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        chk_eq("arst_after_out_valid", 64'(out_valid), 64'd0);
        send(32'd5, 32'd7, 1'b0);
        wait_out_valid(lat);
        chk_eq("arst_new_sum", 64'({cout, sum}), 64'd12);
        step();

        // Back-to-back with in_valid held high
        wait_in_ready();
        out_ready = 1'b1;
        a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        sb_q.push_back(33'h0_0001_0000);
        step();
        t0 = cyc;
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
        sb_q.push_back(33'h1_0000_0000);
        begin
            int k = 0;
            while (!in_ready && k < 100) begin step(); k++; end
        end
        step();
        t1 = cyc;
        in_valid = 1'b0;
        chk_eq("b2b_spacing", 64'(t1 - t0), 64'd10);
        wait_out_valid(lat);
        step();
        wait_in_ready();

        // 8-bit instance
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; in_valid8 = 1'b1;
        sb8_q.push_back(9'h101);
        step();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin step(); lat++; end
        chk_eq("latency8", 64'(lat), 64'd2);
        chk_eq("w8_value", 64'({cout8, sum8}), 64'h101);
        step(); step();

        chk_eq("sb32_drained", 64'(sb_q.size()), 64'd0);
        chk_eq("sb8_drained", 64'(sb8_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
